// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel-advance controls in, counters and decodes out.
interface video_timing_gen_if #(
   parameter int HW = 10,
   parameter int VW = 10
);
   logic          en;
   logic          clr;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [1:0]    hstate;
   logic          hsync;
   logic          vsync;
   logic          cblank;
   logic          csync;
   logic          line_start;
   logic          frame_start;
   logic          field;

   modport master (
      input  en, clr,
      output hcnt, vcnt, hstate, hsync, vsync, cblank,
      output csync, line_start, frame_start, field
   );

   modport slave (
      output en, clr,
      input  hcnt, vcnt, hstate, hsync, vsync, cblank,
      input  csync, line_start, frame_start, field
   );
endinterface

// File: rtl/video_timing_gen.sv
// Video raster timing generator; define VTG_INTERLACE_EN for interlaced
// frames (odd field carries one extra blanked line).
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int HW       = 10,
   parameter int VW       = 10
) (
   input logic                CK,
   input logic                RN,
   video_timing_gen_if.master vt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_A_END = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_F_END = HW'(H_ACTIVE + H_FP - 1);
   localparam logic [HW-1:0] H_S_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SY0   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SY1   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
`ifdef VTG_INTERLACE_EN
   localparam logic [VW-1:0] V_XTRA  = VW'(V_TOTAL);
`endif

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FP     = 2'd1,
      SYNC   = 2'd2,
      BP     = 2'd3
   } hstate_t;

   hstate_t       st, st_n;
   logic [HW-1:0] h, h_n;
   logic [VW-1:0] v, v_n;
   logic          f, f_n;
   logic          v_wrap;
   logic          hs_act, vs_act, blank_n;

   // Next raster position; all outputs are decoded from it so that the
   // registered decodes line up with the registered counters.
   always_comb begin
      st_n   = st;
      h_n    = h;
      v_n    = v;
      f_n    = f;
      v_wrap = 1'b0;
      if (vt.clr) begin
         st_n = ACTIVE;
         h_n  = '0;
         v_n  = '0;
         f_n  = 1'b0;
      end else if (vt.en) begin
         h_n = h + 1'b1;
         unique case (st)
            ACTIVE: if (h == H_A_END) st_n = FP;
            FP:     if (h == H_F_END) st_n = SYNC;
            SYNC:   if (h == H_S_END) st_n = BP;
            BP:     if (h == H_LAST)  st_n = ACTIVE;
         endcase
         if (h == H_LAST) begin
            h_n = '0;
`ifdef VTG_INTERLACE_EN
            v_wrap = f ? (v == V_XTRA) : (v == V_LAST);
            f_n    = f ^ v_wrap;
`else
            v_wrap = (v == V_LAST);
            f_n    = 1'b0;
`endif
            v_n = v_wrap ? '0 : v + 1'b1;
         end
      end
   end

   always_comb begin
      hs_act  = (st_n == SYNC);
      vs_act  = (v_n >= V_SY0) && (v_n <= V_SY1);
      blank_n = (h_n >= H_VIS) || (v_n >= V_VIS);
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         st             <= ACTIVE;
         h              <= '0;
         v              <= '0;
         f              <= 1'b0;
         vt.hsync       <= ~HS_POL;
         vt.vsync       <= ~VS_POL;
         vt.csync       <= ~HS_POL;
         vt.cblank      <= 1'b0;
         vt.line_start  <= 1'b1;
         vt.frame_start <= 1'b1;
      end else if (vt.clr || vt.en) begin
         st             <= st_n;
         h              <= h_n;
         v              <= v_n;
         f              <= f_n;
         vt.hsync       <= hs_act ? HS_POL : ~HS_POL;
         vt.vsync       <= vs_act ? VS_POL : ~VS_POL;
         vt.csync       <= (hs_act || vs_act) ? HS_POL : ~HS_POL;
         vt.cblank      <= blank_n;
         vt.line_start  <= (h_n == '0);
         vt.frame_start <= (h_n == '0) && (v_n == '0);
      end
   end

   assign vt.hcnt   = h;
   assign vt.vcnt   = v;
   assign vt.hstate = st;
   assign vt.field  = f;
endmodule
